stream_out: RTL

STREAM_OUT -- requirements
Module: stream_out

---
 rtl/stream_out_if.sv | 26 ++
 rtl/stream_out.sv | 135 +++++++++++++
 2 files changed

// File: rtl/stream_out_if.sv
// Block-in / word-out bus for stream_out.
// Handshake: a block transfers on a rising edge where vin=1 and rdy=1. rdy is
// a registered "pending slot empty" flag. A vin asserted while rdy=0 is
// dropped. The output side has no backpressure: a word is valid in each
// cycle where vout=1. last marks the eighth word of a block. tout and dout are
// meaningful only while vout=1.
interface stream_out_if;
  logic         vin;
  logic [1:0]   tin;
  logic [127:0] din;
  logic         rdy;
  logic         vout;
  logic [1:0]   tout;
  logic [15:0]  dout;
  logic         last;

  modport master (
    output vin, tin, din,
    input  rdy, vout, tout, dout, last
  );

  modport slave (
    input  vin, tin, din,
    output rdy, vout, tout, dout, last
  );
endinterface

// File: rtl/stream_out.sv
// Serializes 128-bit tagged blocks into eight 16-bit words, MSB word first.
// It has a one-entry pending buffer, so a block arriving mid-send is emitted
// back-to-back with no gap.
module stream_out (
  input  logic         clk,
  input  logic         rst,
  stream_out_if.slave  s,
  output logic         dbg_state
);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_e;

  state_e        state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [111:0]  shift_q, shift_d;   // words still to be emitted after dout
  logic [15:0]   dout_q, dout_d;
  logic [1:0]    tout_q, tout_d;
  logic          vout_q, vout_d;
  logic          last_q, last_d;
  logic          pend_v_q, pend_v_d;
  logic [127:0]  pend_d_q, pend_d_d;
  logic [1:0]    pend_t_q, pend_t_d;

  logic          accept;
  logic          load_in;
  logic          load_pend;
  logic          advance;

  assign accept    = s.vin & ~pend_v_q;
  assign s.rdy     = ~pend_v_q;
  assign s.vout    = vout_q;
  assign s.tout    = tout_q;
  assign s.dout    = dout_q;
  assign s.last    = last_q;
  assign dbg_state = state_q;

  // State and datapath registers, with a synchronous reset that has priority over any accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 3'd0;
      shift_q  <= '0;
      dout_q   <= 16'h0000;
      tout_q   <= 2'b00;
      vout_q   <= 1'b0;
      last_q   <= 1'b0;
      pend_v_q <= 1'b0;
      pend_d_q <= '0;
      pend_t_q <= 2'b00;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      dout_q   <= dout_d;
      tout_q   <= tout_d;
      vout_q   <= vout_d;
      last_q   <= last_d;
      pend_v_q <= pend_v_d;
      pend_d_q <= pend_d_d;
      pend_t_q <= pend_t_d;
    end
  end

  // Next state: the word counter, and which source (din, pending, shift) feeds the next word.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    load_in   = 1'b0;
    load_pend = 1'b0;
    advance   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SEND;
          cnt_d   = 3'd0;
          load_in = 1'b1;
        end
      end
      SEND: begin
        if (cnt_q != 3'd7) begin
          cnt_d   = cnt_q + 3'd1;
          advance = 1'b1;
        end else if (pend_v_q) begin
          cnt_d     = 3'd0;
          load_pend = 1'b1;
        end else if (accept) begin
          cnt_d   = 3'd0;
          load_in = 1'b1;
        end else begin
          state_d = IDLE;
          cnt_d   = 3'd0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 3'd0;
      end
    endcase
  end

  // Outputs and buffers: load or shift the word register, hold it while idle, and fill or drain the pending slot.
  always_comb begin
    shift_d  = shift_q;
    dout_d   = dout_q;
    tout_d   = tout_q;
    pend_v_d = pend_v_q;
    pend_d_d = pend_d_q;
    pend_t_d = pend_t_q;

    if (load_in) begin
      dout_d  = s.din[127:112];
      shift_d = s.din[111:0];
      tout_d  = s.tin;
    end else if (load_pend) begin
      dout_d   = pend_d_q[127:112];
      shift_d  = pend_d_q[111:0];
      tout_d   = pend_t_q;
      pend_v_d = 1'b0;
    end else if (advance) begin
      dout_d  = shift_q[111:96];
      shift_d = {shift_q[95:0], 16'h0000};
    end

    // A block arriving while the current one still has words left is parked.
    if (accept && (state_q == SEND) && (cnt_q != 3'd7)) begin
      pend_v_d = 1'b1;
      pend_d_d = s.din;
      pend_t_d = s.tin;
    end

    vout_d = (state_d == SEND);
    last_d = (state_d == SEND) && (cnt_d == 3'd7);
  end

endmodule
